// File: rtl/spi_mem_bridge.sv
// Turns SPI byte frames (CMD, ADDR_H, ADDR_L, data...) into reads and writes on
// a synchronous byte-wide memory port, with an auto-incrementing address.
module spi_mem_bridge #(
    parameter int AWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        user_out,
    input  logic              user_out_stb,
    output logic [7:0]        user_in,
    input  logic              user_in_ack,
    input  logic              csn_state,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [AWIDTH-1:0] ADDR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_CMD,
        S_ADDR_H,
        S_ADDR_L,
        S_WDATA,
        S_DUMMY,
        S_RDATA,
        S_DISCARD
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_is_read;
    logic              w_is_read_next;
    logic [7:0]        r_addr_hi;
    logic [7:0]        w_addr_hi_next;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH-1:0] w_addr_next;
    logic [AWIDTH-1:0] r_mem_addr;
    logic [AWIDTH-1:0] w_mem_addr_next;
    logic [7:0]        r_mem_wdata;
    logic [7:0]        w_mem_wdata_next;
    logic              r_mem_we;
    logic              w_mem_we_next;
    logic              r_mem_re;
    logic              w_mem_re_next;
    logic              r_rd_pending;
    logic [7:0]        r_user_in;
    logic [7:0]        w_user_in_next;

    logic [15:0]       w_addr_full;
    logic [AWIDTH-1:0] w_addr_rx;
    logic [AWIDTH-1:0] w_addr_rx_inc;
    logic [AWIDTH-1:0] w_addr_inc;

    // Address bits above AWIDTH are dropped; increments wrap modulo 2^AWIDTH.
    assign w_addr_full   = {r_addr_hi, user_out};
    assign w_addr_rx     = w_addr_full[AWIDTH-1:0];
    assign w_addr_rx_inc = w_addr_rx + ADDR_ONE;
    assign w_addr_inc    = r_addr + ADDR_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_CMD;
            r_is_read    <= 1'b0;
            r_addr_hi    <= 8'h00;
            r_addr       <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 8'h00;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_rd_pending <= 1'b0;
            r_user_in    <= 8'h00;
        end else begin
            r_state      <= w_state_next;
            r_is_read    <= w_is_read_next;
            r_addr_hi    <= w_addr_hi_next;
            r_addr       <= w_addr_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_re     <= w_mem_re_next;
            // A read still in flight when CS rises must not reach user_in.
            r_rd_pending <= r_mem_re & ~csn_state;
            r_user_in    <= w_user_in_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (csn_state) begin
            w_state_next = S_CMD;
        end else begin
            case (r_state)
                S_CMD: begin
                    if (user_out_stb) begin
                        if (user_out == CMD_WRITE || user_out == CMD_READ) begin
                            w_state_next = S_ADDR_H;
                        end else begin
                            w_state_next = S_DISCARD;
                        end
                    end
                end
                S_ADDR_H: begin
                    if (user_out_stb) begin
                        w_state_next = S_ADDR_L;
                    end
                end
                S_ADDR_L: begin
                    if (user_out_stb) begin
                        w_state_next = r_is_read ? S_DUMMY : S_WDATA;
                    end
                end
                S_DUMMY: begin
                    if (user_in_ack) begin
                        w_state_next = S_RDATA;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_is_read_next   = r_is_read;
        w_addr_hi_next   = r_addr_hi;
        w_addr_next      = r_addr;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_mem_we_next    = 1'b0;
        w_mem_re_next    = 1'b0;
        w_user_in_next   = r_user_in;

        if (csn_state) begin
            w_user_in_next = 8'h00;
        end else begin
            if (r_rd_pending) begin
                w_user_in_next = mem_rdata;
            end
            case (r_state)
                S_CMD: begin
                    if (user_out_stb) begin
                        w_is_read_next = (user_out == CMD_READ);
                    end
                end
                S_ADDR_H: begin
                    if (user_out_stb) begin
                        w_addr_hi_next = user_out;
                    end
                end
                S_ADDR_L: begin
                    if (user_out_stb) begin
                        w_addr_next = w_addr_rx;
                        if (r_is_read) begin
                            // Prefetch the first byte so it is ready before the dummy ack.
                            w_mem_re_next   = 1'b1;
                            w_mem_addr_next = w_addr_rx;
                            w_addr_next     = w_addr_rx_inc;
                        end
                    end
                end
                S_WDATA: begin
                    if (user_out_stb) begin
                        w_mem_we_next    = 1'b1;
                        w_mem_addr_next  = r_addr;
                        w_mem_wdata_next = user_out;
                        w_addr_next      = w_addr_inc;
                    end
                end
                S_DUMMY, S_RDATA: begin
                    if (user_in_ack) begin
                        w_mem_re_next   = 1'b1;
                        w_mem_addr_next = r_addr;
                        w_addr_next     = w_addr_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign user_in   = r_user_in;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Bench for spi_mem_bridge: table of whole frames plus hand-written read,
// abort, same-cycle and reset sequences against a small registered-read memory.
module tb_spi_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  user_out;
    logic        user_out_stb;
    logic [7:0]  user_in;
    logic        user_in_ack;
    logic        csn_state;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    spi_mem_bridge #(.AWIDTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .user_out     (user_out),
        .user_out_stb (user_out_stb),
        .user_in      (user_in),
        .user_in_ack  (user_in_ack),
        .csn_state    (csn_state),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata)
    );

    // Memory with registered read: data appears the cycle after mem_re.
    bit [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    int          checks = 0;
    int          errors = 0;
    logic [23:0] we_q[$];
    logic [15:0] re_q[$];
    bit          uin_nz;
    int          both_cnt = 0;
    int          width_cnt = 0;
    bit          prev_we = 1'b0;
    bit          prev_re = 1'b0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) we_q.push_back({mem_addr, mem_wdata});
        if (mem_re === 1'b1) re_q.push_back(mem_addr);
        if (mem_we === 1'b1 && mem_re === 1'b1) both_cnt++;
        if ((mem_we === 1'b1 && prev_we) || (mem_re === 1'b1 && prev_re)) width_cnt++;
        prev_we = (mem_we === 1'b1);
        prev_re = (mem_re === 1'b1);
        if (user_in !== 8'h00) uin_nz = 1'b1;
    end

    typedef struct {
        logic [0:7][7:0]  b;
        int               n;
        int               nwe;
        logic [0:3][15:0] wa;
        logic [0:3][7:0]  wd;
        int               nre;
        logic [15:0]      ra;
    } vec_t;

    function automatic vec_t mk(logic [0:7][7:0] b, int n, int nwe,
                                logic [0:3][15:0] wa, logic [0:3][7:0] wd,
                                int nre, logic [15:0] ra);
        vec_t v;
        v.b = b; v.n = n; v.nwe = nwe; v.wa = wa; v.wd = wd; v.nre = nre; v.ra = ra;
        return v;
    endfunction

    logic        post_we;
    logic        post_re;
    logic [15:0] post_addr;
    logic [7:0]  post_wdata;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        user_out     = b;
        user_out_stb = 1'b1;
        tick();
        post_we    = mem_we;
        post_re    = mem_re;
        post_addr  = mem_addr;
        post_wdata = mem_wdata;
        user_out_stb = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_ack(output logic [7:0] got);
        user_in_ack = 1'b1;
        got = user_in;
        tick();
        post_re   = mem_re;
        post_addr = mem_addr;
        user_in_ack = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cs_low();
        csn_state = 1'b0;
        repeat (2) tick();
    endtask

    task automatic cs_high();
        csn_state = 1'b1;
        repeat (3) tick();
    endtask

    task automatic clear_log();
        we_q.delete();
        re_q.delete();
        uin_nz = 1'b0;
    endtask

    vec_t        vec[8];
    logic [7:0]  got;
    logic [0:3][7:0] rd_exp;

    initial begin
        rst = 1'b1; csn_state = 1'b1; user_out = 8'h00;
        user_out_stb = 1'b0; user_in_ack = 1'b0;

        vec[0] = mk({8'h02,8'h01,8'h00,8'h11,8'h22,8'h33,8'h44,8'h00}, 7, 4,
                    {16'h0100,16'h0101,16'h0102,16'h0103}, {8'h11,8'h22,8'h33,8'h44}, 0, 16'h0000);
        vec[1] = mk({8'h02,8'h12,8'h34,8'hAA,8'hBB,8'hCC,8'h00,8'h00}, 6, 3,
                    {16'h1234,16'h1235,16'h1236,16'h0000}, {8'hAA,8'hBB,8'hCC,8'h00}, 0, 16'h0000);
        vec[2] = mk({8'h02,8'hFF,8'hFF,8'h5A,8'h5B,8'h00,8'h00,8'h00}, 5, 2,
                    {16'hFFFF,16'h0000,16'h0000,16'h0000}, {8'h5A,8'h5B,8'h00,8'h00}, 0, 16'h0000);
        vec[3] = mk({8'h07,8'h00,8'h00,8'h99,8'h99,8'h00,8'h00,8'h00}, 5, 0,
                    {16'h0000,16'h0000,16'h0000,16'h0000}, {8'h00,8'h00,8'h00,8'h00}, 0, 16'h0000);
        vec[4] = mk({8'h02,8'h00,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00}, 4, 1,
                    {16'h0000,16'h0000,16'h0000,16'h0000}, {8'h01,8'h00,8'h00,8'h00}, 0, 16'h0000);
        vec[5] = mk({8'h02,8'h00,8'h40,8'hA5,8'h00,8'h00,8'h00,8'h00}, 4, 1,
                    {16'h0040,16'h0000,16'h0000,16'h0000}, {8'hA5,8'h00,8'h00,8'h00}, 0, 16'h0000);
        vec[6] = mk({8'h03,8'h00,8'h40,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0,
                    {16'h0000,16'h0000,16'h0000,16'h0000}, {8'h00,8'h00,8'h00,8'h00}, 1, 16'h0040);
        vec[7] = mk({8'hFF,8'h01,8'h02,8'h03,8'h00,8'h00,8'h00,8'h00}, 4, 0,
                    {16'h0000,16'h0000,16'h0000,16'h0000}, {8'h00,8'h00,8'h00,8'h00}, 0, 16'h0000);

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_user_in", user_in, 8'h00);
        chk("reset_mem_addr", mem_addr, 16'h0000);
        chk("reset_mem_wdata", mem_wdata, 8'h00);
        chk("reset_mem_we", mem_we, 1'b0);
        chk("reset_mem_re", mem_re, 1'b0);

        // Table of complete frames
        for (int i = 0; i < 8; i++) begin
            clear_log();
            cs_low();
            for (int k = 0; k < vec[i].n; k++) send_byte(vec[i].b[k]);
            cs_high();
            $display("frame %0d cmd %02h: %0d writes %0d reads", i, vec[i].b[0], we_q.size(), re_q.size());
            chk($sformatf("v%0d_we_count", i), we_q.size(), vec[i].nwe);
            for (int j = 0; j < vec[i].nwe; j++) begin
                if (j < we_q.size()) begin
                    chk($sformatf("v%0d_we%0d_addr", i, j), we_q[j][23:8], vec[i].wa[j]);
                    chk($sformatf("v%0d_we%0d_data", i, j), we_q[j][7:0], vec[i].wd[j]);
                end
            end
            chk($sformatf("v%0d_re_count", i), re_q.size(), vec[i].nre);
            if (vec[i].nre > 0 && re_q.size() > 0)
                chk($sformatf("v%0d_re_addr", i), re_q[0], vec[i].ra);
            if (vec[i].nre == 0)
                chk($sformatf("v%0d_user_in_zero", i), uin_nz, 1'b0);
        end

        // Read burst from 0x0100 (holds 11 22 33 44)
        clear_log();
        cs_low();
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h00);
        chk("rd_re_after_addrl", post_re, 1'b1);
        chk("rd_re_addr", post_addr, 16'h0100);
        chk("rd_user_in_before_dummy", user_in, 8'h11);
        rd_exp = {8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) begin
            send_ack(got);
            $display("read ack %0d: user_in %02h", k, got);
            chk($sformatf("rd_byte%0d", k), got, rd_exp[k]);
            chk($sformatf("rd_ack%0d_re", k), post_re, 1'b1);
            chk($sformatf("rd_ack%0d_addr", k), post_addr, 16'h0101 + 16'(k));
        end
        send_byte(8'hEE);
        chk("rd_stb_ignored_we", post_we, 1'b0);
        chk("rd_stb_ignored_re", post_re, 1'b0);
        cs_high();
        chk("rd_user_in_after_cs", user_in, 8'h00);
        chk("rd_re_count", re_q.size(), 5);
        chk("rd_we_count", we_q.size(), 0);

        // CS rise after 02 00: next frame must start at CMD
        clear_log();
        cs_low();
        send_byte(8'h02);
        send_byte(8'h00);
        cs_high();
        cs_low();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h77);
        $display("abort frame: we %0b addr %04h data %02h", post_we, post_addr, post_wdata);
        chk("abort_we_latency", post_we, 1'b1);
        chk("abort_we_addr", post_addr, 16'h0010);
        chk("abort_we_data", post_wdata, 8'h77);
        cs_high();
        chk("abort_we_count", we_q.size(), 1);

        // stb and ack together in WDATA: write happens, ack ignored
        clear_log();
        cs_low();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h30);
        user_out = 8'h5C; user_out_stb = 1'b1; user_in_ack = 1'b1;
        tick();
        $display("stb+ack: we %0b re %0b addr %04h", mem_we, mem_re, mem_addr);
        chk("both_we", mem_we, 1'b1);
        chk("both_re", mem_re, 1'b0);
        chk("both_addr", mem_addr, 16'h0030);
        user_out_stb = 1'b0; user_in_ack = 1'b0;
        repeat (4) tick();
        cs_high();
        chk("both_re_count", re_q.size(), 0);

        // CS rise with a read in flight: its data must not reach user_in
        clear_log();
        cs_low();
        send_byte(8'h03);
        send_byte(8'h00);
        user_out = 8'h40; user_out_stb = 1'b1;
        tick();
        user_out_stb = 1'b0;
        chk("inflight_re", mem_re, 1'b1);
        csn_state = 1'b1;
        repeat (4) tick();
        $display("inflight read abort: user_in %02h", user_in);
        chk("inflight_user_in", user_in, 8'h00);
        chk("inflight_re_count", re_q.size(), 1);

        // rst mid-RDATA, then a fresh write frame without toggling CS
        clear_log();
        cs_low();
        send_byte(8'h03);
        send_byte(8'h01);
        send_byte(8'h00);
        send_ack(got);
        send_ack(got);
        rst = 1'b1;
        tick();
        $display("rst mid-read: user_in %02h addr %04h wdata %02h", user_in, mem_addr, mem_wdata);
        chk("rst_user_in", user_in, 8'h00);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_mem_wdata", mem_wdata, 8'h00);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_re", mem_re, 1'b0);
        rst = 1'b0;
        tick();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h20);
        send_byte(8'h66);
        chk("post_rst_we", post_we, 1'b1);
        chk("post_rst_addr", post_addr, 16'h0020);
        chk("post_rst_data", post_wdata, 8'h66);
        cs_high();

        chk("we_re_overlap", both_cnt, 0);
        chk("pulse_width", width_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
